// File: rtl/lcd_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module   : lcd_seq_pkg
// Purpose  : Shared state encoding, HD44780 instruction codes, init ROM and
//            helper functions for the LCD write sequencer.
// Revision : 1.0 - initial release
// ============================================================================
package lcd_seq_pkg;

    typedef enum logic [2:0] {
        ST_PWRUP     = 3'd0,
        ST_INIT_LOAD = 3'd1,
        ST_SETUP     = 3'd2,
        ST_PULSE     = 3'd3,
        ST_HOLD      = 3'd4,
        ST_WAIT      = 3'd5,
        ST_IDLE      = 3'd6
    } lcd_state_t;

    localparam int unsigned c_INIT_LEN = 6;

    localparam logic [7:0] c_CLEAR     = 8'h01;
    localparam logic [7:0] c_HOME      = 8'h02;
    localparam logic [7:0] c_FUNC_8B2L = 8'h38;
    localparam logic [7:0] c_DISP_ON   = 8'h0C;
    localparam logic [7:0] c_ENTRY_INC = 8'h06;

    localparam logic [7:0] c_INIT_ROM [c_INIT_LEN] = '{
        c_FUNC_8B2L, c_FUNC_8B2L, c_FUNC_8B2L, c_DISP_ON, c_CLEAR, c_ENTRY_INC
    };

    // Clear and home (0x01..0x03) need the long execution wait.
    function automatic logic is_long_wait(input logic rs, input logic [7:0] data);
        return !rs && (data[7:2] == 6'd0) && (data != 8'd0);
    endfunction

    function automatic int unsigned cyc_max(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage
`default_nettype wire

// File: rtl/lcd_delay_counter.sv
`default_nettype none
// ============================================================================
// Module   : lcd_delay_counter
// Purpose  : Loadable down-counter that saturates at zero; done while zero.
// Revision : 1.0 - initial release
// ============================================================================
module lcd_delay_counter #(
    parameter int unsigned      WIDTH       = 8,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic             clk,
    input  logic             i_rst_n,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_load_value,
    output logic             o_done
);

    logic [WIDTH-1:0] r_count;

    always_ff @(posedge clk) begin
        if (!i_rst_n) begin
            r_count <= RESET_VALUE;
        end else if (i_load) begin
            r_count <= i_load_value;
        end else if (r_count != '0) begin
            r_count <= r_count - 1'b1;
        end
    end

    assign o_done = (r_count == '0);

endmodule
`default_nettype wire

// File: rtl/lcd_write_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : lcd_write_sequencer
// Purpose  : HD44780 power-up init plus valid/ready byte writes with E-strobe
//            timing. Optional macro LCD_SEQ_REINIT_EN adds a reinit_req input.
// Revision : 1.0 - initial release
// ============================================================================
module lcd_write_sequencer
    import lcd_seq_pkg::*;
#(
    parameter int unsigned SETUP_CYC      = 4,
    parameter int unsigned PULSE_CYC      = 12,
    parameter int unsigned HOLD_CYC       = 2,
    parameter int unsigned SHORT_WAIT_CYC = 2000,
    parameter int unsigned LONG_WAIT_CYC  = 82000,
    parameter int unsigned PWRUP_WAIT_CYC = 2000000
) (
    input  logic       clk_clk,
    input  logic       reset_reset_n,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic       cmd_rs,
    input  logic [7:0] cmd_data,
`ifdef LCD_SEQ_REINIT_EN
    input  logic       reinit_req,
`endif
    output logic [7:0] lcd_data,
    output logic       lcd_enable,
    output logic       lcd_rs,
    output logic       lcd_rw,
    output logic       init_done,
    output logic       busy
);

    localparam int unsigned c_MAX_CYC = cyc_max(cyc_max(cyc_max(SETUP_CYC, PULSE_CYC),
                                                        cyc_max(HOLD_CYC, SHORT_WAIT_CYC)),
                                                cyc_max(LONG_WAIT_CYC, PWRUP_WAIT_CYC));
    localparam int unsigned c_CNT_W = $clog2(c_MAX_CYC) + 1;

    localparam logic [c_CNT_W-1:0] c_SETUP_LD = c_CNT_W'(SETUP_CYC - 1);
    localparam logic [c_CNT_W-1:0] c_PULSE_LD = c_CNT_W'(PULSE_CYC - 1);
    localparam logic [c_CNT_W-1:0] c_HOLD_LD  = c_CNT_W'(HOLD_CYC - 1);
    localparam logic [c_CNT_W-1:0] c_SHORT_LD = c_CNT_W'(SHORT_WAIT_CYC - 1);
    localparam logic [c_CNT_W-1:0] c_LONG_LD  = c_CNT_W'(LONG_WAIT_CYC - 1);
    localparam logic [c_CNT_W-1:0] c_PWRUP_LD = c_CNT_W'(PWRUP_WAIT_CYC - 1);
    localparam logic [2:0]         c_LAST_IDX = 3'(c_INIT_LEN - 1);

    lcd_state_t         r_state, w_next_state;
    logic [2:0]         r_idx, w_next_idx;
    logic               r_init_done, w_next_init_done;
    logic [7:0]         r_lcd_data;
    logic               r_lcd_rs, r_lcd_enable, r_cmd_ready, r_busy;
    logic               w_cnt_load, w_cnt_done;
    logic [c_CNT_W-1:0] w_cnt_value;
    logic               w_take_rom, w_take_cmd;
    logic               w_reinit, w_cmd_ready, w_handshake;

`ifdef LCD_SEQ_REINIT_EN
    // Reinit pre-empts a simultaneous command, so ready is masked that cycle.
    assign w_reinit    = reinit_req && (r_state == ST_IDLE);
    assign w_cmd_ready = r_cmd_ready && !reinit_req;
`else
    assign w_reinit    = 1'b0;
    assign w_cmd_ready = r_cmd_ready;
`endif

    assign w_handshake = cmd_valid && w_cmd_ready;

    lcd_delay_counter #(
        .WIDTH       (c_CNT_W),
        .RESET_VALUE (c_PWRUP_LD)
    ) u_delay (
        .clk          (clk_clk),
        .i_rst_n      (reset_reset_n),
        .i_load       (w_cnt_load),
        .i_load_value (w_cnt_value),
        .o_done       (w_cnt_done)
    );

    // INIT_LOAD presents the ROM byte on the bus and counts as the first
    // setup cycle, so init writes see exactly SETUP_CYC of setup time.
    always_comb begin
        w_next_state     = r_state;
        w_next_idx       = r_idx;
        w_next_init_done = r_init_done;
        w_cnt_load       = 1'b0;
        w_cnt_value      = '0;
        w_take_rom       = 1'b0;
        w_take_cmd       = 1'b0;
        case (r_state)
            ST_PWRUP: begin
                if (w_cnt_done) begin
                    w_next_state = ST_INIT_LOAD;
                    w_take_rom   = 1'b1;
                    w_cnt_load   = 1'b1;
                    w_cnt_value  = c_SETUP_LD;
                end
            end
            ST_INIT_LOAD: begin
                if (w_cnt_done) begin
                    w_next_state = ST_PULSE;
                    w_cnt_load   = 1'b1;
                    w_cnt_value  = c_PULSE_LD;
                end else begin
                    w_next_state = ST_SETUP;
                end
            end
            ST_SETUP: begin
                if (w_cnt_done) begin
                    w_next_state = ST_PULSE;
                    w_cnt_load   = 1'b1;
                    w_cnt_value  = c_PULSE_LD;
                end
            end
            ST_PULSE: begin
                if (w_cnt_done) begin
                    w_next_state = ST_HOLD;
                    w_cnt_load   = 1'b1;
                    w_cnt_value  = c_HOLD_LD;
                end
            end
            ST_HOLD: begin
                if (w_cnt_done) begin
                    w_next_state = ST_WAIT;
                    w_cnt_load   = 1'b1;
                    w_cnt_value  = is_long_wait(r_lcd_rs, r_lcd_data) ? c_LONG_LD : c_SHORT_LD;
                end
            end
            ST_WAIT: begin
                if (w_cnt_done) begin
                    if (r_init_done) begin
                        w_next_state = ST_IDLE;
                    end else if (r_idx == c_LAST_IDX) begin
                        w_next_state     = ST_IDLE;
                        w_next_init_done = 1'b1;
                    end else begin
                        w_next_state = ST_INIT_LOAD;
                        w_next_idx   = r_idx + 3'd1;
                        w_take_rom   = 1'b1;
                        w_cnt_load   = 1'b1;
                        w_cnt_value  = c_SETUP_LD;
                    end
                end
            end
            ST_IDLE: begin
                if (w_reinit) begin
                    w_next_state     = ST_INIT_LOAD;
                    w_next_idx       = 3'd0;
                    w_next_init_done = 1'b0;
                    w_take_rom       = 1'b1;
                    w_cnt_load       = 1'b1;
                    w_cnt_value      = c_SETUP_LD;
                end else if (w_handshake) begin
                    w_next_state = ST_SETUP;
                    w_take_cmd   = 1'b1;
                    w_cnt_load   = 1'b1;
                    w_cnt_value  = c_SETUP_LD;
                end
            end
            default: begin
                w_next_state = ST_PWRUP;
            end
        endcase
    end

    always_ff @(posedge clk_clk) begin
        if (!reset_reset_n) begin
            r_state      <= ST_PWRUP;
            r_idx        <= 3'd0;
            r_init_done  <= 1'b0;
            r_lcd_data   <= 8'd0;
            r_lcd_rs     <= 1'b0;
            r_lcd_enable <= 1'b0;
            r_cmd_ready  <= 1'b0;
            r_busy       <= 1'b1;
        end else begin
            r_state     <= w_next_state;
            r_idx       <= w_next_idx;
            r_init_done <= w_next_init_done;
            if (w_take_rom) begin
                r_lcd_rs   <= 1'b0;
                r_lcd_data <= c_INIT_ROM[w_next_idx];
            end else if (w_take_cmd) begin
                r_lcd_rs   <= cmd_rs;
                r_lcd_data <= cmd_data;
            end
            r_lcd_enable <= (w_next_state == ST_PULSE);
            r_cmd_ready  <= (w_next_state == ST_IDLE) && w_next_init_done;
            r_busy       <= (w_next_state != ST_IDLE);
        end
    end

    assign cmd_ready  = w_cmd_ready;
    assign lcd_data   = r_lcd_data;
    assign lcd_enable = r_lcd_enable;
    assign lcd_rs     = r_lcd_rs;
    assign lcd_rw     = 1'b0;
    assign init_done  = r_init_done;
    assign busy       = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_lcd_write_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_lcd_write_sequencer
// Purpose  : Directed self-checking bench for lcd_write_sequencer.
// Revision : 1.0 - initial release
// ============================================================================
module tb_lcd_write_sequencer;

    logic       clk_clk = 1'b0;
    logic       reset_reset_n = 1'b0;
    logic       cmd_valid = 1'b0;
    logic       cmd_rs = 1'b0;
    logic [7:0] cmd_data = 8'd0;
    logic       cmd_ready, lcd_enable, lcd_rs, lcd_rw, init_done, busy;
    logic [7:0] lcd_data;
`ifdef LCD_SEQ_REINIT_EN
    logic       reinit_req = 1'b0;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    // init capture results
    logic [7:0] cap_bytes [8];
    int         cap_w [8];
    int         cap_n, cap_first, cap_done_k, cap_ready_k, cap_rs_bad;

    // single command results
    int         c_ready_dly, c_en_first, c_en_w, c_en_cnt;
    logic [7:0] c_en_data, c_setup_data;
    logic       c_en_rs, c_setup_rs;

    logic [7:0] exp_rom [6] = '{8'h38, 8'h38, 8'h38, 8'h0C, 8'h01, 8'h06};

    always #5 clk_clk = ~clk_clk;

    lcd_write_sequencer #(
        .SETUP_CYC      (2),
        .PULSE_CYC      (3),
        .HOLD_CYC       (1),
        .SHORT_WAIT_CYC (5),
        .LONG_WAIT_CYC  (20),
        .PWRUP_WAIT_CYC (10)
    ) dut (
        .clk_clk       (clk_clk),
        .reset_reset_n (reset_reset_n),
        .cmd_valid     (cmd_valid),
        .cmd_ready     (cmd_ready),
        .cmd_rs        (cmd_rs),
        .cmd_data      (cmd_data),
`ifdef LCD_SEQ_REINIT_EN
        .reinit_req    (reinit_req),
`endif
        .lcd_data      (lcd_data),
        .lcd_enable    (lcd_enable),
        .lcd_rs        (lcd_rs),
        .lcd_rw        (lcd_rw),
        .init_done     (init_done),
        .busy          (busy)
    );

    task automatic tick;
        @(posedge clk_clk);
        #1;
    endtask

    // Releases reset (caller has just sampled a reset edge) and records the init pulses.
    task automatic run_init;
        logic prev;
        int   cur;
        prev = 1'b0; cur = 0;
        cap_n = 0; cap_first = -1; cap_done_k = -1; cap_ready_k = -1; cap_rs_bad = 0;
        for (int i = 0; i < 8; i++) begin
            cap_w[i] = 0; cap_bytes[i] = 8'd0;
        end
        reset_reset_n = 1'b1;
        for (int k = 1; k <= 200; k++) begin
            tick();
            if (lcd_enable) begin
                if (!prev) begin
                    if (cap_first < 0) cap_first = k;
                    if (cap_n < 8) cap_bytes[cap_n] = lcd_data;
                    if (lcd_rs) cap_rs_bad++;
                    cap_n++;
                    cur = 0;
                end
                cur++;
            end else if (prev && cap_n >= 1 && cap_n <= 8) begin
                cap_w[cap_n-1] = cur;
            end
            prev = lcd_enable;
            if (cmd_ready && cap_ready_k < 0) cap_ready_k = k;
            if (init_done && cap_done_k < 0) cap_done_k = k;
            if (cap_done_k >= 0) break;
        end
    endtask

    // One handshake; offset 0 is the sample just after the handshake edge.
    task automatic run_cmd(input logic rs, input logic [7:0] d);
        logic prev;
        prev = 1'b0;
        for (int i = 0; i < 300 && !cmd_ready; i++) tick();
        if (!cmd_ready) begin
            n_tests++; n_fail++;
            $display("FAIL cmd_wait: cmd_ready=%0b required 1", cmd_ready);
        end
        cmd_valid = 1'b1; cmd_rs = rs; cmd_data = d;
        tick();
        cmd_valid = 1'b0; cmd_rs = ~rs; cmd_data = ~d;
        c_ready_dly = -1; c_en_first = -1; c_en_w = 0; c_en_cnt = 0;
        c_en_data = 8'd0; c_en_rs = 1'b0;
        c_setup_data = lcd_data; c_setup_rs = lcd_rs;
        for (int off = 0; off < 100; off++) begin
            if (off > 0) tick();
            if (lcd_enable) begin
                c_en_w++;
                if (!prev) begin
                    c_en_cnt++;
                    if (c_en_first < 0) begin
                        c_en_first = off; c_en_data = lcd_data; c_en_rs = lcd_rs;
                    end
                end
            end
            prev = lcd_enable;
            if (cmd_ready) begin
                c_ready_dly = off;
                break;
            end
        end
    endtask

    task automatic test_reset;
        reset_reset_n = 1'b0; cmd_valid = 1'b0;
        tick(); tick(); tick();
        n_tests++; if (lcd_data !== 8'h00) begin n_fail++; $display("FAIL reset_data: got %h expected 00", lcd_data); end
        n_tests++; if (lcd_enable !== 1'b0) begin n_fail++; $display("FAIL reset_enable: got %b expected 0", lcd_enable); end
        n_tests++; if (lcd_rs !== 1'b0) begin n_fail++; $display("FAIL reset_rs: got %b expected 0", lcd_rs); end
        n_tests++; if (lcd_rw !== 1'b0) begin n_fail++; $display("FAIL reset_rw: got %b expected 0", lcd_rw); end
        n_tests++; if (cmd_ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready: got %b expected 0", cmd_ready); end
        n_tests++; if (init_done !== 1'b0) begin n_fail++; $display("FAIL reset_init_done: got %b expected 0", init_done); end
        n_tests++; if (busy !== 1'b1) begin n_fail++; $display("FAIL reset_busy: got %b expected 1", busy); end
    endtask

    task automatic test_init;
        run_init();
        // first E after PWRUP (10) + SETUP (2); done after 10 + 5*11 + 26
        n_tests++; if (cap_first != 12) begin n_fail++; $display("FAIL init_first_e: got %0d expected 12", cap_first); end
        n_tests++; if (cap_done_k != 91) begin n_fail++; $display("FAIL init_done_time: got %0d expected 91", cap_done_k); end
        n_tests++; if (cap_ready_k != 91) begin n_fail++; $display("FAIL init_ready_time: got %0d expected 91", cap_ready_k); end
        n_tests++; if (cap_n != 6) begin n_fail++; $display("FAIL init_pulses: got %0d expected 6", cap_n); end
        n_tests++; if (cap_rs_bad != 0) begin n_fail++; $display("FAIL init_rs: got %0d rs=1 pulses expected 0", cap_rs_bad); end
        for (int i = 0; i < 6; i++) begin
            n_tests++; if (cap_bytes[i] !== exp_rom[i]) begin n_fail++; $display("FAIL init_byte%0d: got %h expected %h", i, cap_bytes[i], exp_rom[i]); end
            n_tests++; if (cap_w[i] != 3) begin n_fail++; $display("FAIL init_width%0d: got %0d expected 3", i, cap_w[i]); end
        end
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL init_busy: got %b expected 0", busy); end
    endtask

    task automatic test_data_write;
        run_cmd(1'b1, 8'h41);
        n_tests++; if (c_setup_rs !== 1'b1 || c_setup_data !== 8'h41) begin n_fail++; $display("FAIL dw_setup: got rs=%b data=%h expected rs=1 data=41", c_setup_rs, c_setup_data); end
        n_tests++; if (c_ready_dly != 11) begin n_fail++; $display("FAIL dw_ready: got %0d expected 11", c_ready_dly); end
        n_tests++; if (c_en_first != 2) begin n_fail++; $display("FAIL dw_e_start: got %0d expected 2", c_en_first); end
        n_tests++; if (c_en_w != 3 || c_en_cnt != 1) begin n_fail++; $display("FAIL dw_e_shape: got width=%0d pulses=%0d expected 3/1", c_en_w, c_en_cnt); end
        n_tests++; if (c_en_rs !== 1'b1 || c_en_data !== 8'h41) begin n_fail++; $display("FAIL dw_e_bus: got rs=%b data=%h expected rs=1 data=41", c_en_rs, c_en_data); end
        n_tests++; if (lcd_data !== 8'h41 || lcd_rs !== 1'b1) begin n_fail++; $display("FAIL dw_keep: got rs=%b data=%h expected rs=1 data=41", lcd_rs, lcd_data); end
        n_tests++; if (lcd_rw !== 1'b0) begin n_fail++; $display("FAIL dw_rw: got %b expected 0", lcd_rw); end
    endtask

    task automatic test_long_wait;
        run_cmd(1'b0, 8'h01);
        n_tests++; if (c_ready_dly != 26) begin n_fail++; $display("FAIL long_01: got %0d expected 26", c_ready_dly); end
        n_tests++; if (c_en_rs !== 1'b0 || c_en_data !== 8'h01) begin n_fail++; $display("FAIL long_bus: got rs=%b data=%h expected rs=0 data=01", c_en_rs, c_en_data); end
        run_cmd(1'b0, 8'h03);
        n_tests++; if (c_ready_dly != 26) begin n_fail++; $display("FAIL long_03: got %0d expected 26", c_ready_dly); end
    endtask

    task automatic test_short_instr;
        run_cmd(1'b0, 8'h00);
        n_tests++; if (c_ready_dly != 11) begin n_fail++; $display("FAIL short_00: got %0d expected 11", c_ready_dly); end
        run_cmd(1'b0, 8'h04);
        n_tests++; if (c_ready_dly != 11) begin n_fail++; $display("FAIL short_04: got %0d expected 11", c_ready_dly); end
        run_cmd(1'b1, 8'h01);
        n_tests++; if (c_ready_dly != 11) begin n_fail++; $display("FAIL short_data01: got %0d expected 11", c_ready_dly); end
    endtask

    task automatic test_back_to_back;
        logic [7:0] bytes [4];
        int         pulses, phase, first_ready;
        logic       prev, done, ready0;
        pulses = 0; phase = 0; first_ready = -1; prev = 1'b0; done = 1'b0;
        for (int i = 0; i < 4; i++) bytes[i] = 8'd0;
        for (int i = 0; i < 300 && !cmd_ready; i++) tick();
        cmd_valid = 1'b1; cmd_rs = 1'b1; cmd_data = 8'hA0;
        tick();
        ready0 = cmd_ready;
        for (int c = 0; c < 80 && !done; c++) begin
            if (lcd_enable && !prev) begin
                if (pulses < 4) bytes[pulses] = lcd_data;
                pulses++;
            end
            prev = lcd_enable;
            if (phase == 0) begin
                if (cmd_ready) begin
                    first_ready = c; cmd_data = 8'h55; phase = 1;
                end else begin
                    cmd_data = 8'(8'hC0 + c);
                end
            end else if (phase == 1) begin
                cmd_valid = 1'b0; phase = 2;
            end else if (cmd_ready) begin
                done = 1'b1;
            end
            if (!done) tick();
        end
        cmd_valid = 1'b0;
        n_tests++; if (ready0 !== 1'b0) begin n_fail++; $display("FAIL b2b_ready_drop: got %b expected 0", ready0); end
        n_tests++; if (first_ready != 11) begin n_fail++; $display("FAIL b2b_ready_time: got %0d expected 11", first_ready); end
        n_tests++; if (!done) begin n_fail++; $display("FAIL b2b_finish: got done=%b expected 1", done); end
        n_tests++; if (pulses != 2) begin n_fail++; $display("FAIL b2b_pulses: got %0d expected 2", pulses); end
        n_tests++; if (bytes[0] !== 8'hA0) begin n_fail++; $display("FAIL b2b_byte0: got %h expected a0", bytes[0]); end
        n_tests++; if (bytes[1] !== 8'h55) begin n_fail++; $display("FAIL b2b_byte1: got %h expected 55", bytes[1]); end
    endtask

    task automatic test_reset_mid_pulse;
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < 300 && !cmd_ready; i++) tick();
        cmd_valid = 1'b1; cmd_rs = 1'b1; cmd_data = 8'h7E;
        tick();
        cmd_valid = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            if (lcd_enable) seen = 1'b1;
            else tick();
        end
        n_tests++; if (!seen) begin n_fail++; $display("FAIL rmp_pulse_seen: got %b expected 1", seen); end
        reset_reset_n = 1'b0;
        tick();
        n_tests++; if (lcd_enable !== 1'b0) begin n_fail++; $display("FAIL rmp_enable: got %b expected 0", lcd_enable); end
        n_tests++; if (busy !== 1'b1 || cmd_ready !== 1'b0 || init_done !== 1'b0) begin n_fail++; $display("FAIL rmp_flags: got busy=%b ready=%b done=%b expected 1/0/0", busy, cmd_ready, init_done); end
        n_tests++; if (lcd_data !== 8'h00 || lcd_rs !== 1'b0) begin n_fail++; $display("FAIL rmp_bus: got rs=%b data=%h expected rs=0 data=00", lcd_rs, lcd_data); end
        run_init();
        n_tests++; if (cap_first != 12) begin n_fail++; $display("FAIL rmp_first_e: got %0d expected 12", cap_first); end
        n_tests++; if (cap_n != 6) begin n_fail++; $display("FAIL rmp_pulses: got %0d expected 6", cap_n); end
        n_tests++; if (cap_done_k != 91) begin n_fail++; $display("FAIL rmp_done_time: got %0d expected 91", cap_done_k); end
        n_tests++; if (cap_bytes[5] !== 8'h06) begin n_fail++; $display("FAIL rmp_last_byte: got %h expected 06", cap_bytes[5]); end
    endtask

    initial begin
        test_reset();
        test_init();
        test_data_write();
        test_long_wait();
        test_short_instr();
        test_back_to_back();
        test_reset_mid_pulse();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire

// File: doc/lcd_write_sequencer.md
Name: lcd_write_sequencer

Overview:
- Hardware sequencer for the character LCD bus: lcd_data, lcd_enable, lcd_rs, lcd_rw.
- Runs the HD44780-style power-up init, then accepts command/data bytes over a valid/ready handshake.
- Generates the E-strobe timing (setup, pulse, hold) and the per-instruction execution wait.
- Sits between the processor-side LCD port logic and the external LCD pins.

Parameters:
- SETUP_CYC, 4: cycles rs/data are stable before lcd_enable rises (>=1).
- PULSE_CYC, 12: cycles lcd_enable is high (>=1).
- HOLD_CYC, 2: cycles rs/data are held after lcd_enable falls (>=1).
- SHORT_WAIT_CYC, 2000: execution wait for normal instructions and data writes (>=1).
- LONG_WAIT_CYC, 82000: execution wait for clear/home instructions (>=1).
- PWRUP_WAIT_CYC, 2000000: delay after reset before the first init write (>=1).

Ports:
- clk_clk  in  1  system clock.
- reset_reset_n  in  1  reset; synchronous, active-low.
- cmd_valid  in  1  request to write a byte.
- cmd_ready  out  1  sequencer can accept a byte this cycle.
- cmd_rs  in  1  0 = instruction, 1 = data.
- cmd_data  in  8  byte to write.
- lcd_data  out  8  LCD data bus.
- lcd_enable  out  1  LCD E strobe.
- lcd_rs  out  1  LCD register select.
- lcd_rw  out  1  LCD read/write; constant 0 (write-only).
- init_done  out  1  high once the init sequence has completed.
- busy  out  1  high whenever the FSM is not in IDLE.

Behaviour:
- Reset values (while reset_reset_n=0 at an edge): lcd_data=0, lcd_enable=0, lcd_rs=0, lcd_rw=0, cmd_ready=0, init_done=0, busy=1, state=PWRUP.
- All outputs are registered.
- States:
  - PWRUP -> INIT_LOAD after PWRUP_WAIT_CYC cycles.
  - INIT_LOAD -> SETUP: loads init ROM entry idx (rs=0).
  - SETUP (SETUP_CYC) -> PULSE (PULSE_CYC, lcd_enable=1) -> HOLD (HOLD_CYC) -> WAIT (SHORT_WAIT_CYC or LONG_WAIT_CYC).
  - WAIT end during init: idx < 5 -> INIT_LOAD with idx+1; idx = 5 -> IDLE and set init_done.
  - WAIT end after init: -> IDLE.
- Init ROM, in order: 0x38, 0x38, 0x38, 0x0C, 0x01, 0x06.
- Wait selection: LONG when rs=0 and data[7:2]==0 and data!=0 (codes 0x01..0x03); SHORT otherwise, including 0x00.
- Handshake:
  - cmd_ready = 1 only in IDLE, and only after init_done.
  - A transfer occurs on an edge where cmd_valid && cmd_ready; rs/data are latched to lcd_rs/lcd_data and the FSM enters SETUP.
  - cmd_ready drops on the next cycle.
  - cmd_valid while cmd_ready=0 is ignored; no buffering, and the requester must hold the request.
- Latency: with the handshake at edge N, lcd_enable is high for cycles N+SETUP_CYC+1 .. N+SETUP_CYC+PULSE_CYC.
  - cmd_ready returns after SETUP_CYC+PULSE_CYC+HOLD_CYC+wait cycles in non-IDLE states.
- lcd_data/lcd_rs stay stable from SETUP through HOLD and keep the last value afterwards.
- lcd_enable is never high outside PULSE.
- Delay counter:
  - Width is $clog2 of the maximum parameter plus 1.
  - Loaded with N-1 on state entry; the state exits when the counter reads 0.
  - No wrap-around.
- Reset mid-operation (any state, including PULSE): the next edge forces reset values; lcd_enable drops in the same cycle; the init sequence restarts in full.

Optional Feature:
- Macro: LCD_SEQ_REINIT_EN.
- With it defined:
  - An extra input port reinit_req (1 bit) is added.
  - reinit_req=1 in IDLE clears init_done, sets idx=0 and enters INIT_LOAD; PWRUP is skipped.
  - reinit_req is ignored in other states.
  - If reinit_req and a cmd handshake occur in the same cycle, reinit wins and cmd_ready is 0 in that cycle.
- Without it: the port is absent; init runs only after reset.

Decomposition:
- Package lcd_seq_pkg:
  - state enum (PWRUP, INIT_LOAD, SETUP, PULSE, HOLD, WAIT, IDLE).
  - INIT_LEN=6 and the init ROM constant array.
  - Instruction codes: CLEAR=0x01, HOME=0x02, FUNC_8B2L=0x38, DISP_ON=0x0C, ENTRY_INC=0x06.
- Sub-module lcd_delay_counter: load value, load strobe, done flag. Shared by the PWRUP, SETUP, PULSE, HOLD and WAIT states.

Test Plan:
All scenarios use SETUP_CYC=2, PULSE_CYC=3, HOLD_CYC=1, SHORT_WAIT_CYC=5, LONG_WAIT_CYC=20, PWRUP_WAIT_CYC=10.
- Init sequence: release reset and leave cmd_valid low.
  - Expect 6 E pulses, each 3 cycles, carrying 0x38, 0x38, 0x38, 0x0C, 0x01, 0x06 with rs=0.
  - init_done and cmd_ready rise exactly 91 cycles after release.
- Data write: after init, cmd_valid with rs=1, data=0x41.
  - lcd_rs=1 and lcd_data=0x41 for 2 cycles, then E high 3 cycles, then hold 1.
  - cmd_ready returns 11 cycles after the handshake.
- Long wait: cmd rs=0, data=0x01 -> cmd_ready returns after 26 cycles.
- Short instruction: data=0x00 with rs=0 -> cmd_ready returns after 11 cycles (short wait).
- Backpressure: cmd_valid held high with varying data during busy.
  - Only the byte present at the ready cycle is written.
  - Exactly one E pulse per handshake.
- Reset mid-PULSE: assert reset_reset_n=0 for 1 cycle while lcd_enable=1.
  - lcd_enable=0 on the next edge.
  - Full init replays; the first E pulse appears after PWRUP_WAIT_CYC.
